// File: rtl/aes_top.sv
// AES-256 known-answer self-test top: encrypts a fixed FIPS-197 block forever,
// one round per clock, with a scope trigger framing each encryption.
module aes_top (
    input  logic TOP_Clk,
    input  logic TOP_ResetAll,
    output logic CompareFlag_p,
    output logic trigger
);

    localparam logic [255:0] KEY    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] EXP_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_DONE,
        S_GAP
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        logic [7:0] y;
        acc = '0;
        x   = a;
        y   = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[0]) acc = acc ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return acc;
    endfunction

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 for free
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int unsigned i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    fsm_t           fsm_q, fsm_d;
    logic [127:0]   state_q, state_d;
    logic [255:0]   kreg_q, kreg_d;
    logic [3:0]     round_q, round_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [3:0]     gap_q, gap_d;
    logic           trigger_q, trigger_d;
    logic           cmp_q, cmp_d;

    logic [7:0]     sb_b [16];
    logic [127:0]   sr_w;
    logic [127:0]   mc_w;
    logic [31:0]    ks_in, ks_sub, ks_t;
    logic [31:0]    nw0, nw1, nw2, nw3;
    logic [255:0]   key_next;

    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign sb_b[k] = sbox(state_q[127-8*k -: 8]);
        assign sr_w[127-8*k -: 8] = sb_b[4*(((k/4) + (k%4)) % 4) + (k%4)];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr_w[127-32*c -: 8];
        assign a1 = sr_w[119-32*c -: 8];
        assign a2 = sr_w[111-32*c -: 8];
        assign a3 = sr_w[103-32*c -: 8];
        assign mc_w[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end

    // kreg is a sliding 8-word window: each round appends four new words, so
    // the low half always holds the key for the round being executed.
    // Odd rounds produce words i%8==0 (RotWord+Rcon), even rounds the SubWord-only half.
    assign ks_in = round_q[0] ? {kreg_q[23:0], kreg_q[31:24]} : kreg_q[31:0];

    for (genvar j = 0; j < 4; j++) begin : g_ksb
        assign ks_sub[8*j +: 8] = sbox(ks_in[8*j +: 8]);
    end

    assign ks_t     = ks_sub ^ (round_q[0] ? {rcon_q, 24'h000000} : 32'h00000000);
    assign nw0      = kreg_q[255:224] ^ ks_t;
    assign nw1      = kreg_q[223:192] ^ nw0;
    assign nw2      = kreg_q[191:160] ^ nw1;
    assign nw3      = kreg_q[159:128] ^ nw2;
    assign key_next = {kreg_q[127:0], nw0, nw1, nw2, nw3};

    always_ff @(posedge TOP_Clk or negedge TOP_ResetAll) begin
        if (!TOP_ResetAll) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  fsm_d = S_LOAD;
            S_LOAD:  fsm_d = S_ROUND;
            S_ROUND: if (round_q == 4'd14) fsm_d = S_DONE;
            S_DONE:  fsm_d = S_GAP;
            S_GAP:   if (gap_q == 4'd1) fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        kreg_d    = kreg_q;
        round_d   = round_q;
        rcon_d    = rcon_q;
        gap_d     = gap_q;
        trigger_d = trigger_q;
        cmp_d     = cmp_q;
        case (fsm_q)
            S_IDLE: begin
                kreg_d = KEY;
                rcon_d = 8'h01;
            end
            S_LOAD: begin
                state_d   = PT ^ kreg_q[255:128];
                round_d   = 4'd1;
                trigger_d = 1'b1;
            end
            S_ROUND: begin
                if (round_q == 4'd14) begin
                    state_d   = sr_w ^ kreg_q[127:0];
                    trigger_d = 1'b0;
                end else begin
                    state_d = mc_w ^ kreg_q[127:0];
                    kreg_d  = key_next;
                    round_d = round_q + 4'd1;
                    if (round_q[0]) rcon_d = xtime(rcon_q);
                end
            end
            S_DONE: begin
                cmp_d = (state_q == EXP_CT);
                gap_d = 4'd8;
            end
            S_GAP: begin
                gap_d = gap_q - 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge TOP_Clk or negedge TOP_ResetAll) begin
        if (!TOP_ResetAll) begin
            state_q   <= '0;
            kreg_q    <= KEY;
            round_q   <= '0;
            rcon_q    <= 8'h01;
            gap_q     <= '0;
            trigger_q <= 1'b0;
            cmp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            kreg_q    <= kreg_d;
            round_q   <= round_d;
            rcon_q    <= rcon_d;
            gap_q     <= gap_d;
            trigger_q <= trigger_d;
            cmp_q     <= cmp_d;
        end
    end

    assign trigger       = trigger_q;
    assign CompareFlag_p = cmp_q;

endmodule

// File: tb/tb_aes_top.sv
// Scoreboard bench for aes_top: expected trigger/flag/state per cycle after
// each reset release are queued up front and compared every falling edge.
module tb_aes_top;

    localparam logic [127:0] CT_EXP   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] ST_LOAD  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] ST_ROUND1 = 128'h4f63760643e0aa85efa7213201a4e705;

    typedef struct {
        int unsigned  cyc;
        logic         trig;
        logic         flag;
        logic         chk_st;
        logic [127:0] st;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flag;
    logic trig;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned cyc;
    exp_t        exp_q[$];

    aes_top dut (
        .TOP_Clk       (clk),
        .TOP_ResetAll  (rst_n),
        .CompareFlag_p (flag),
        .trigger       (trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n counts rising edges since reset release; period is 25 edges.
    function automatic exp_t model(input int unsigned n);
        exp_t e;
        int unsigned p;
        p        = ((n - 1) % 25) + 1;
        e.cyc    = n;
        e.trig   = (p >= 2 && p <= 15);
        e.flag   = (n >= 17);
        e.chk_st = 1'b0;
        e.st     = '0;
        if (p == 2)  begin e.chk_st = 1'b1; e.st = ST_LOAD;   end
        if (p == 3)  begin e.chk_st = 1'b1; e.st = ST_ROUND1; end
        if (p == 16) begin e.chk_st = 1'b1; e.st = CT_EXP;    end
        return e;
    endfunction

    task automatic push_range(input int unsigned first, input int unsigned last);
        for (int unsigned n = first; n <= last; n++) exp_q.push_back(model(n));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 65; i++) begin
            @(negedge clk);
            n_checks++;
            if (trig !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_trigger i=%0d got %b want 0", i, trig);
            end
            n_checks++;
            if (flag !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flag i=%0d got %b want 0", i, flag);
            end
        end
    endtask

    task automatic test_first_encryption();
        exp_t e;
        release_reset();
        push_range(1, 25);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (trig !== e.trig) begin
                n_fail++;
                $display("FAIL first_trigger cyc=%0d got %b want %b", e.cyc, trig, e.trig);
            end
            n_checks++;
            if (flag !== e.flag) begin
                n_fail++;
                $display("FAIL first_flag cyc=%0d got %b want %b", e.cyc, flag, e.flag);
            end
            if (e.chk_st) begin
                n_checks++;
                if (dut.state_q !== e.st) begin
                    n_fail++;
                    $display("FAIL first_state cyc=%0d got %h want %h", e.cyc, dut.state_q, e.st);
                end
            end
        end
    endtask

    task automatic test_free_run();
        exp_t        e;
        logic        prev;
        int unsigned last_rise;
        int unsigned n_rise;
        prev      = trig;
        last_rise = 0;
        n_rise    = 0;
        push_range(26, 150);
        for (int i = 0; i < 125; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (trig !== e.trig) begin
                n_fail++;
                $display("FAIL run_trigger cyc=%0d got %b want %b", e.cyc, trig, e.trig);
            end
            n_checks++;
            if (flag !== e.flag) begin
                n_fail++;
                $display("FAIL run_flag cyc=%0d got %b want %b", e.cyc, flag, e.flag);
            end
            if (e.chk_st) begin
                n_checks++;
                if (dut.state_q !== e.st) begin
                    n_fail++;
                    $display("FAIL run_state cyc=%0d got %h want %h", e.cyc, dut.state_q, e.st);
                end
            end
            if (trig === 1'b1 && prev === 1'b0) begin
                if (n_rise > 0) begin
                    n_checks++;
                    if (cyc - last_rise !== 25) begin
                        n_fail++;
                        $display("FAIL rise_spacing cyc=%0d got %0d want 25", cyc, cyc - last_rise);
                    end
                end
                last_rise = cyc;
                n_rise++;
            end
            prev = trig;
        end
        n_checks++;
        if (n_rise !== 5) begin
            n_fail++;
            $display("FAIL rise_count got %0d want 5", n_rise);
        end
    endtask

    task automatic test_reset_midround();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        release_reset();
        push_range(1, 35);
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (trig !== e.trig || flag !== e.flag) begin
                n_fail++;
                $display("FAIL pre_abort cyc=%0d got trig=%b flag=%b want trig=%b flag=%b",
                         e.cyc, trig, flag, e.trig, e.flag);
            end
        end
        // Edge 10 of the second encryption has just passed; abort between edges.
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (trig !== 1'b0 || flag !== 1'b0) begin
            n_fail++;
            $display("FAIL async_abort got trig=%b flag=%b want 0 0", trig, flag);
        end
        n_checks++;
        if (dut.state_q !== '0) begin
            n_fail++;
            $display("FAIL abort_state got %h want 0", dut.state_q);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (trig !== 1'b0 || flag !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_hold i=%0d got trig=%b flag=%b want 0 0", i, trig, flag);
            end
        end
        release_reset();
        push_range(1, 17);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (trig !== e.trig) begin
                n_fail++;
                $display("FAIL restart_trigger cyc=%0d got %b want %b", e.cyc, trig, e.trig);
            end
            n_checks++;
            if (flag !== e.flag) begin
                n_fail++;
                $display("FAIL restart_flag cyc=%0d got %b want %b", e.cyc, flag, e.flag);
            end
            if (e.chk_st) begin
                n_checks++;
                if (dut.state_q !== e.st) begin
                    n_fail++;
                    $display("FAIL restart_state cyc=%0d got %h want %h", e.cyc, dut.state_q, e.st);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b1;
        test_reset();
        test_first_encryption();
        test_free_run();
        test_reset_midround();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
